prbs_checker: RTL and testbench

- Receive-side checker for word streams produced by the team's Galois LFSR generator (one full LFSR state word per valid beat).
- Seeds a local expected-state register from the incoming stream and qualifies lock over consecutive matching words.
- Once locked, free-runs (flywheels) its expected sequence and counts mismatching words.
- Drops lock after persistent loss.
- Used in BIST/link-test paths opposite the generator.

---
 rtl/prbs_pkg.sv | 33 +++
 rtl/prbs_sat_cnt.sv | 41 ++++
 rtl/prbs_checker.sv | 175 +++++++++++++++++
 tb/tb_prbs_checker.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// Shared types and the Galois LFSR step for the PRBS generator/checker pair.
// The step function works on a fixed maximum width; callers pass their real width.
package prbs_pkg;

  localparam int PRBS_MAX_W = 64;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } prbs_state_e;

  // Bits at and above 'width' are returned as zero; poly[width-1] is never looked at.
  function automatic logic [PRBS_MAX_W-1:0] lfsr_galois_next(
    input logic [PRBS_MAX_W-1:0] q,
    input logic [PRBS_MAX_W-1:0] poly,
    input int                    width
  );
    logic [PRBS_MAX_W-1:0] sh;
    logic [PRBS_MAX_W-1:0] nxt;
    sh  = q >> 1;
    nxt = '0;
    for (int i = 0; i < PRBS_MAX_W; i++) begin
      if (i + 1 < width) begin
        nxt[i] = sh[i] ^ (poly[i] & q[0]);
      end else if (i + 1 == width) begin
        nxt[i] = q[0];
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/prbs_sat_cnt.sv
// Saturating accumulator with synchronous clear (clear beats increment).
module prbs_sat_cnt #(
  parameter int WIDTH     = 16,
  parameter int INC_WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 en,
  input  logic [INC_WIDTH-1:0] inc,
  output logic [WIDTH-1:0]     cnt
);

  // One extra bit so the overflow of cnt + inc is visible before clamping.
  localparam int SUM_W = ((WIDTH > INC_WIDTH) ? WIDTH : INC_WIDTH) + 1;

  logic [SUM_W-1:0] sum;
  logic [SUM_W-1:0] max_val;
  logic [WIDTH-1:0] cnt_next;

  assign sum     = SUM_W'(cnt) + SUM_W'(inc);
  assign max_val = SUM_W'({WIDTH{1'b1}});

  always_comb begin
    cnt_next = cnt;
    if (clr) begin
      cnt_next = '0;
    end else if (en) begin
      cnt_next = (sum > max_val) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/prbs_checker.sv
// Receive-side PRBS checker: HUNT -> VERIFY -> LOCKED with a flywheeling expected word.
// Define PRBS_CHECKER_BITERR_EN to add the bit_err_cnt_o bit-error accumulator.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] POLY       = '0,
  parameter int                    LOCK_CNT   = 4,
  parameter int                    LOSS_CNT   = 8,
  parameter int                    CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  input  logic                  clr_i,
  input  logic                  restart_i,
  output logic                  lock_o,
  output logic                  err_o,
  output logic [CNT_WIDTH-1:0]  err_cnt_o
`ifdef PRBS_CHECKER_BITERR_EN
  ,
  output logic [CNT_WIDTH-1:0]  bit_err_cnt_o
`endif
);

  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int MISS_W  = $clog2(LOSS_CNT + 1);
  localparam logic [PRBS_MAX_W-1:0] POLY_W = PRBS_MAX_W'(POLY);

  generate
    if (POLY[DATA_WIDTH-2:0] == '0) begin : g_bad_poly
      $error("prbs_checker: POLY must have at least one tap below the top bit");
    end
    if (DATA_WIDTH > PRBS_MAX_W || DATA_WIDTH < 4) begin : g_bad_width
      $error("prbs_checker: DATA_WIDTH out of range");
    end
  endgenerate

  prbs_state_e           state_reg, state_next;
  logic [DATA_WIDTH-1:0] exp_reg, exp_next;
  logic [MATCH_W-1:0]    match_cnt_reg, match_cnt_next;
  logic [MISS_W-1:0]     miss_cnt_reg, miss_cnt_next;
  logic                  lock_reg, err_reg, err_next;
  logic                  cnt_inc;
  logic                  cnt_clr;

  logic [DATA_WIDTH-1:0] step_dat;
  logic [DATA_WIDTH-1:0] step_exp;
  logic [MATCH_W-1:0]    match_inc;
  logic [MISS_W-1:0]     miss_inc;
  logic                  is_match;
  logic                  dat_zero;

  assign step_dat  = DATA_WIDTH'(lfsr_galois_next(PRBS_MAX_W'(dat_i), POLY_W, DATA_WIDTH));
  assign step_exp  = DATA_WIDTH'(lfsr_galois_next(PRBS_MAX_W'(exp_reg), POLY_W, DATA_WIDTH));
  assign match_inc = match_cnt_reg + MATCH_W'(1);
  assign miss_inc  = miss_cnt_reg + MISS_W'(1);
  assign is_match  = (dat_i == exp_reg);
  assign dat_zero  = (dat_i == '0);

  always_comb begin
    state_next     = state_reg;
    exp_next       = exp_reg;
    match_cnt_next = match_cnt_reg;
    miss_cnt_next  = miss_cnt_reg;
    err_next       = 1'b0;
    cnt_inc        = 1'b0;
    if (restart_i) begin
      state_next     = HUNT;
      match_cnt_next = '0;
      miss_cnt_next  = '0;
    end else if (valid_i) begin
      unique case (state_reg)
        HUNT: begin
          if (!dat_zero) begin
            exp_next       = step_dat;
            match_cnt_next = '0;
            state_next     = VERIFY;
          end
        end
        VERIFY: begin
          // exp is never zero here, so a zero word always lands in the mismatch path.
          if (is_match) begin
            exp_next       = step_exp;
            match_cnt_next = match_inc;
            if (match_inc == MATCH_W'(LOCK_CNT)) begin
              state_next    = LOCKED;
              miss_cnt_next = '0;
            end
          end else if (dat_zero) begin
            state_next     = HUNT;
            match_cnt_next = '0;
          end else begin
            exp_next       = step_dat;
            match_cnt_next = '0;
          end
        end
        LOCKED: begin
          exp_next = step_exp;
          if (is_match) begin
            miss_cnt_next = '0;
          end else begin
            err_next      = 1'b1;
            cnt_inc       = 1'b1;
            miss_cnt_next = miss_inc;
            if (miss_inc == MISS_W'(LOSS_CNT)) begin
              state_next     = HUNT;
              match_cnt_next = '0;
            end
          end
        end
        default: begin
          state_next = HUNT;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg     <= HUNT;
      exp_reg       <= '0;
      match_cnt_reg <= '0;
      miss_cnt_reg  <= '0;
      lock_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      exp_reg       <= exp_next;
      match_cnt_reg <= match_cnt_next;
      miss_cnt_reg  <= miss_cnt_next;
      lock_reg      <= (state_next == LOCKED);
      err_reg       <= err_next;
    end
  end

  assign lock_o  = lock_reg;
  assign err_o   = err_reg;
  // restart outranks clear, so a clear alongside restart is ignored.
  assign cnt_clr = clr_i & ~restart_i;

  prbs_sat_cnt #(
    .WIDTH     (CNT_WIDTH),
    .INC_WIDTH (1)
  ) u_word_cnt (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .clr   (cnt_clr),
    .en    (cnt_inc),
    .inc   (1'b1),
    .cnt   (err_cnt_o)
  );

`ifdef PRBS_CHECKER_BITERR_EN
  localparam int BIT_INC_W = $clog2(DATA_WIDTH + 1);

  logic [BIT_INC_W-1:0] bit_inc;

  assign bit_inc = BIT_INC_W'($countones(dat_i ^ exp_reg));

  prbs_sat_cnt #(
    .WIDTH     (CNT_WIDTH),
    .INC_WIDTH (BIT_INC_W)
  ) u_bit_cnt (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .clr   (cnt_clr),
    .en    (cnt_inc),
    .inc   (bit_inc),
    .cnt   (bit_err_cnt_o)
  );
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: 8-bit LFSR, POLY 0x1D, LOCK_CNT 2, LOSS_CNT 8.
// A second instance with a 2-bit counter shares the stimulus to exercise saturation.
module tb_prbs_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid;
  logic [7:0] dat;
  logic       clr;
  logic       restart;

  logic        lock, err;
  logic [15:0] cnt;
  logic        lock_s, err_s;
  logic [1:0]  cnt_s;
`ifdef PRBS_CHECKER_BITERR_EN
  logic [15:0] bcnt;
  logic [1:0]  bcnt_s;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  prbs_checker #(
    .DATA_WIDTH (8), .POLY (8'h1D), .LOCK_CNT (2), .LOSS_CNT (8), .CNT_WIDTH (16)
  ) dut (
    .clk_i (clk), .rst_n_i (rst_n), .valid_i (valid), .dat_i (dat),
    .clr_i (clr), .restart_i (restart),
    .lock_o (lock), .err_o (err), .err_cnt_o (cnt)
`ifdef PRBS_CHECKER_BITERR_EN
    , .bit_err_cnt_o (bcnt)
`endif
  );

  prbs_checker #(
    .DATA_WIDTH (8), .POLY (8'h1D), .LOCK_CNT (2), .LOSS_CNT (8), .CNT_WIDTH (2)
  ) dut_sat (
    .clk_i (clk), .rst_n_i (rst_n), .valid_i (valid), .dat_i (dat),
    .clr_i (clr), .restart_i (restart),
    .lock_o (lock_s), .err_o (err_s), .err_cnt_o (cnt_s)
`ifdef PRBS_CHECKER_BITERR_EN
    , .bit_err_cnt_o (bcnt_s)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // One beat: drive on a falling edge, sampled at the rising edge, outputs read at the next falling edge.
  task automatic send(input logic [7:0] d, input logic c, input logic r);
    @(negedge clk);
    valid   = 1'b1;
    dat     = d;
    clr     = c;
    restart = r;
    @(negedge clk);
    valid   = 1'b0;
    clr     = 1'b0;
    restart = 1'b0;
  endtask

  task automatic send_lock(input string tag);
    send(8'h01, 1'b0, 1'b0); check({tag, " lock b1"}, lock, 0);
    send(8'h9D, 1'b0, 1'b0); check({tag, " lock b2"}, lock, 0);
    send(8'hD3, 1'b0, 1'b0); check({tag, " lock b3"}, lock, 1);
  endtask

  // Sequence from seed 01 continues F4 7A 3D 83 DC 6E 37 86 43 BC 5E 2F 8A.
  logic [7:0] garbage [8] = '{8'h23, 8'h91, 8'hC8, 8'h79, 8'hBC, 8'h43, 8'hA1, 8'hD0};

  initial begin
    rst_n = 1'b0; valid = 1'b0; dat = '0; clr = 1'b0; restart = 1'b0;
    repeat (3) @(negedge clk);
    check("rst lock", lock, 0);
    check("rst err", err, 0);
    check("rst cnt", cnt, 0);
    rst_n = 1'b1;

    // Acquire lock
    send_lock("acq");
    check("acq cnt", cnt, 0);

    // Single corrupted word, then flywheel keeps lock
    send(8'hF4, 1'b0, 1'b0); check("good err", err, 0);
    send(8'h7B, 1'b0, 1'b0);
    check("one err", err, 1);
    check("one cnt", cnt, 1);
    check("one lock", lock, 1);
`ifdef PRBS_CHECKER_BITERR_EN
    check("one bits", bcnt, 1);
`endif
    send(8'h3D, 1'b0, 1'b0);
    check("after err", err, 0);
    check("after lock", lock, 1);
    check("after cnt", cnt, 1);
    send(8'h83, 1'b0, 1'b0);

    // Eight inverted words: lock holds through seven, drops on the eighth
    for (int i = 0; i < 8; i++) begin
      send(garbage[i], 1'b0, 1'b0);
      check($sformatf("loss%0d err", i), err, 1);
      check($sformatf("loss%0d lock", i), lock, (i < 7) ? 1 : 0);
    end
    check("loss cnt", cnt, 9);
    check("loss sat cnt", cnt_s, 3);
`ifdef PRBS_CHECKER_BITERR_EN
    check("loss bits", bcnt, 65);
`endif

    // Zero words in HUNT are ignored
    for (int i = 0; i < 3; i++) begin
      send(8'h00, 1'b0, 1'b0);
      check($sformatf("zero%0d lock", i), lock, 0);
      check($sformatf("zero%0d err", i), err, 0);
    end
    send_lock("relock");

    // Further error saturates the narrow counter; clear with an erroring beat
    send(8'h0B, 1'b0, 1'b0);
    check("sat cnt", cnt, 10);
    check("sat cnt2", cnt_s, 3);
    send(8'h85, 1'b1, 1'b0);
    check("clr err", err, 1);
    check("clr cnt", cnt, 0);
    check("clr cnt2", cnt_s, 0);
`ifdef PRBS_CHECKER_BITERR_EN
    check("clr bits", bcnt, 0);
`endif
    send(8'h3D, 1'b0, 1'b0);
    check("post clr err", err, 0);
    check("post clr lock", lock, 1);

    // Restart discards the concurrent (bad) beat and keeps the count
    send(8'h7C, 1'b0, 1'b0);
    check("pre rst cnt", cnt, 1);
    send(8'h55, 1'b0, 1'b1);
    check("restart lock", lock, 0);
    check("restart err", err, 0);
    check("restart cnt", cnt, 1);
    send(8'h6E, 1'b0, 1'b0); check("reseed lock", lock, 0);
    send(8'h37, 1'b0, 1'b0); check("reseed lock2", lock, 0);
    send(8'h86, 1'b0, 1'b0); check("reseed lock3", lock, 1);

    // Asynchronous reset between clock edges
    send(8'hBC, 1'b0, 1'b0);
    check("pre arst err", err, 1);
    check("pre arst cnt", cnt, 2);
    #2 rst_n = 1'b0;
    #1;
    check("arst lock", lock, 0);
    check("arst err", err, 0);
    check("arst cnt", cnt, 0);
`ifdef PRBS_CHECKER_BITERR_EN
    check("arst bits", bcnt, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h5E, 1'b0, 1'b0); check("post arst lock", lock, 0);
    send_lock("post arst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
